// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 registered-feedback bus bundle between a master and the burst BRAM slave.
interface wb_bram_burst_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADR_WIDTH  = 32
);
    logic [ADR_WIDTH-1:0]    adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;

    modport master (
        output adr, dat_ms, sel, we, cyc, stb, cti, bte,
        input  dat_sm, ack, err
    );

    modport slave (
        input  adr, dat_ms, sel, we, cyc, stb, cti, bte,
        output dat_sm, ack, err
    );
endinterface

// File: rtl/wb_bram_burst.sv
// Wishbone slave over a byte-lane-writable block RAM: zero-wait writes, registered reads
// with constant/incrementing/wrapping burst support.
module wb_bram_burst #(
    parameter int DATA_BYTES    = 4,
    parameter int MEM_ADR_WIDTH = 11,
    parameter int ADR_WIDTH     = 32
) (
    input  logic           clk,
    input  logic           rst,
    wb_bram_burst_if.slave wb
);
    localparam int LB    = $clog2(DATA_BYTES);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int DEPTH = 1 << MEM_ADR_WIDTH;
    localparam int TOP   = LB + MEM_ADR_WIDTH;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic logic [DW-1:0] lane_mask(input logic [DATA_BYTES-1:0] s);
        logic [DW-1:0] m;
        m = {DW{1'b0}};
        for (int b = 0; b < DATA_BYTES; b++) begin
            m[8*b +: 8] = {8{s[b]}};
        end
        return m;
    endfunction

    // Wrapping bursts only advance the low log2(N) bits; linear uses a full mask.
    function automatic logic [MEM_ADR_WIDTH-1:0] next_word(
        input logic [MEM_ADR_WIDTH-1:0] w,
        input logic [2:0]               cti,
        input logic [1:0]               bte
    );
        logic [MEM_ADR_WIDTH-1:0] m;
        case (bte)
            2'b01:   m = MEM_ADR_WIDTH'(4'd3);
            2'b10:   m = MEM_ADR_WIDTH'(4'd7);
            2'b11:   m = MEM_ADR_WIDTH'(4'd15);
            default: m = {MEM_ADR_WIDTH{1'b1}};
        endcase
        if (cti == 3'b001) begin
            return w;
        end else begin
            return (w & ~m) | ((w + MEM_ADR_WIDTH'(1'b1)) & m);
        end
    endfunction

    logic [DW-1:0]            mem [DEPTH];

    state_t                   state_q, state_d;
    logic                     ack_q, ack_d;
    logic [DW-1:0]            dat_q, dat_d;
    logic [MEM_ADR_WIDTH-1:0] nxt_q, nxt_d;

    logic                     valid_s;
    logic                     in_range_s;
    logic                     cti_bad_s;
    logic                     err_s;
    logic                     wr_ack_s;
    logic                     rd_ok_s;
    logic [MEM_ADR_WIDTH-1:0] word_s;
    logic [MEM_ADR_WIDTH-1:0] rd_word_s;
    logic [DW-1:0]            rd_data_s;

    assign valid_s    = wb.cyc & wb.stb;
    assign in_range_s = ((wb.adr >> TOP) == {ADR_WIDTH{1'b0}});
    assign cti_bad_s  = (wb.cti >= 3'd3) && (wb.cti <= 3'd6);
    assign err_s      = valid_s & (~in_range_s | cti_bad_s);
    assign wr_ack_s   = valid_s & wb.we & ~err_s & ~rst;
    assign rd_ok_s    = valid_s & ~wb.we & ~err_s;
    assign word_s     = wb.adr[LB +: MEM_ADR_WIDTH];

    // During a burst the address comes from the internal pointer, never from adr.
    assign rd_word_s  = (state_q == BURST) ? nxt_q : word_s;
    assign rd_data_s  = mem[rd_word_s];

    assign wb.err     = err_s;
    assign wb.ack     = ~err_s & ~rst & valid_s & (wr_ack_s | ack_q);
    assign wb.dat_sm  = dat_q & lane_mask(wb.sel);

    // Byte-lane write port; contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_ack_s) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (wb.sel[b]) begin
                    mem[word_s][8*b +: 8] <= wb.dat_ms[8*b +: 8];
                end
            end
        end
    end

    // Read FSM state, registered ack, read data and burst pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= {DW{1'b0}};
            nxt_q   <= {MEM_ADR_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            nxt_q   <= nxt_d;
        end
    end

    // Read sequencing: classic reads take two cycles, bursts stream one beat per cycle.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        nxt_d   = nxt_q;
        case (state_q)
            IDLE: begin
                if (ack_q) begin
                    ack_d = 1'b0;
                end else if (rd_ok_s) begin
                    ack_d = 1'b1;
                    dat_d = rd_data_s;
                    nxt_d = next_word(word_s, wb.cti, wb.bte);
                    if ((wb.cti == 3'b001) || (wb.cti == 3'b010)) begin
                        state_d = BURST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ack_d = 1'b0;
                end
            end
            BURST: begin
                if (!valid_s || wb.we || err_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else if (ack_q && (wb.cti != 3'b111)) begin
                    ack_d = 1'b1;
                    dat_d = rd_data_s;
                    nxt_d = next_word(nxt_q, wb.cti, wb.bte);
                end else begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst; stimulus queues expected responses, a negedge monitor checks them.
module tb_wb_bram_burst;
    logic clk;
    logic rst;

    wb_bram_burst_if #(.DATA_BYTES(4), .ADR_WIDTH(32)) wb ();

    wb_bram_burst #(
        .DATA_BYTES   (4),
        .MEM_ADR_WIDTH(11),
        .ADR_WIDTH    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb (wb)
    );

    typedef struct {
        int          kind;   // 0 write ack, 1 read data, 2 error
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_cnt);
        end
    endtask

    // Monitor: every qualified response must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        chk("ack_err_exclusive", {31'd0, wb.ack & wb.err}, 32'd0);
        if (wb.cyc && wb.stb && (wb.ack || wb.err)) begin
            kind = wb.err ? 2 : (wb.we ? 0 : 1);
            if (sb.size() == 0) begin
                chk("unexpected_response", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("resp_kind", 32'(kind), 32'(e.kind));
                chk("resp_cycle", 32'(cyc_cnt), 32'(e.cyc));
                if (e.kind == 1) chk("read_data", wb.dat_sm, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = 32'd0;
        wb.sel = 4'd0; wb.cti = 3'd0; wb.bte = 2'd0; wb.dat_ms = 32'd0;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [2:0] c, input logic [1:0] b, input logic [31:0] d);
        wb.adr = a; wb.we = w; wb.sel = s; wb.cti = c; wb.bte = b; wb.dat_ms = d;
        wb.cyc = 1'b1; wb.stb = 1'b1;
    endtask

    task automatic expect_resp(input int kind, input int cyc, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.cyc = cyc; e.data = d;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        drive(a, 1'b1, s, 3'b000, 2'b00, d);
        expect_resp(0, cyc_cnt, 32'd0);
        tick();
        idle_bus();
    endtask

    task automatic err_access(input logic [31:0] a, input logic w, input logic [2:0] c, input logic [31:0] d);
        drive(a, w, 4'hF, c, 2'b00, d);
        expect_resp(2, cyc_cnt, 32'd0);
        tick();
        idle_bus();
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] s, input logic [31:0] expd);
        drive(a, 1'b0, s, 3'b000, 2'b00, 32'd0);
        expect_resp(1, cyc_cnt + 1, expd);
        tick();
        tick();
        idle_bus();
    endtask

    // Beat k is acked in cycle base+1+k; later beats present a bogus adr that must be ignored.
    task automatic rd_burst(input logic [31:0] a, input logic [1:0] b, input logic [2:0] c,
                            input int n, input logic [31:0] e [8]);
        int base;
        base = cyc_cnt;
        drive(a, 1'b0, 4'hF, (n > 1) ? c : 3'b111, b, 32'd0);
        for (int k = 0; k < n; k++) expect_resp(1, base + 1 + k, e[k]);
        tick();
        for (int k = 1; k < n; k++) begin
            tick();
            wb.adr = 32'h0000_0100;
            wb.cti = (k == n - 1) ? 3'b111 : c;
        end
        tick();
        idle_bus();
    endtask

    initial begin
        int base;
        rst = 1'b1;
        idle_bus();
        #2;
        chk("reset_ack", {31'd0, wb.ack}, 32'd0);
        chk("reset_err", {31'd0, wb.err}, 32'd0);
        wb.sel = 4'hF;
        #1;
        chk("reset_dat_sm", wb.dat_sm, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        idle_bus();

        // Full write, single-lane overwrite, classic readback.
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        wr(32'h10, 32'h0000AA00, 4'b0010);
        rd(32'h10, 4'hF, 32'hDEADAAEF);

        // Held classic read: acks every other cycle, unselected lanes read as zero.
        base = cyc_cnt;
        drive(32'h10, 1'b0, 4'b0011, 3'b000, 2'b00, 32'd0);
        expect_resp(1, base + 1, 32'h0000AAEF);
        expect_resp(1, base + 3, 32'h0000AAEF);
        tick(); tick(); tick(); tick();
        idle_bus();

        for (int k = 0; k < 8; k++) wr(32'(k * 4), 32'(k), 4'hF);

        rd_burst(32'h18, 2'b01, 3'b010, 4, '{32'd6, 32'd7, 32'd4, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0});
        rd_burst(32'h18, 2'b10, 3'b010, 4, '{32'd6, 32'd7, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0});
        rd_burst(32'h0C, 2'b00, 3'b001, 3, '{32'd3, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});

        // Linear burst rolls over from the last word to word 0.
        wr(32'h1FFC, 32'h12345678, 4'hF);
        rd_burst(32'h1FFC, 2'b00, 3'b010, 2, '{32'h12345678, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});

        // Out-of-range and reserved cycle types error out without writing.
        err_access(32'h2000, 1'b0, 3'b000, 32'd0);
        err_access(32'h2000, 1'b1, 3'b000, 32'hFFFFFFFF);
        rd(32'h0, 4'hF, 32'd0);
        err_access(32'h4, 1'b1, 3'b100, 32'hFFFFFFFF);
        err_access(32'h4, 1'b0, 3'b011, 32'd0);
        rd(32'h4, 4'hF, 32'd1);

        // stb dropped for one cycle after beat 2, then the burst restarts from adr.
        base = cyc_cnt;
        drive(32'h0, 1'b0, 4'hF, 3'b010, 2'b00, 32'd0);
        expect_resp(1, base + 1, 32'd0);
        expect_resp(1, base + 2, 32'd1);
        tick(); tick();
        wb.adr = 32'h100;
        tick();
        wb.stb = 1'b0;
        tick();
        base = cyc_cnt;
        drive(32'h8, 1'b0, 4'hF, 3'b010, 2'b00, 32'd0);
        expect_resp(1, base + 1, 32'd2);
        expect_resp(1, base + 2, 32'd3);
        tick(); tick();
        wb.cti = 3'b111;
        tick();
        idle_bus();

        // Reset during beat 3 of an 8-beat burst.
        base = cyc_cnt;
        drive(32'h0, 1'b0, 4'hF, 3'b010, 2'b00, 32'd0);
        expect_resp(1, base + 1, 32'd0);
        expect_resp(1, base + 2, 32'd1);
        tick(); tick();
        wb.adr = 32'h100;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_burst_ack", {31'd0, wb.ack}, 32'd0);
        chk("rst_mid_burst_dat", wb.dat_sm, 32'd0);
        tick();
        idle_bus();
        tick();
        rst = 1'b0;

        for (int k = 0; k < 8; k++) rd(32'(k * 4), 4'hF, 32'(k));
        rd(32'h1FFC, 4'b1000, 32'h12000000);

        tick();
        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
